// File: rtl/wb_ext_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one external slave between tile masters.
// The grant is held for a whole cyc, and a watchdog terminates hung strobes with an error.
module wb_ext_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                              clk,
    input  logic                              rst_sys,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   m_adr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   m_dat_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] m_sel_i,
    input  logic [NUM_PORTS-1:0]              m_cyc_i,
    input  logic [NUM_PORTS-1:0]              m_stb_i,
    input  logic [NUM_PORTS-1:0]              m_we_i,
    input  logic [NUM_PORTS*3-1:0]            m_cti_i,
    input  logic [NUM_PORTS*2-1:0]            m_bte_i,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]   m_dat_o,
    output logic [NUM_PORTS-1:0]              m_ack_o,
    output logic [NUM_PORTS-1:0]              m_err_o,
    output logic [NUM_PORTS-1:0]              m_rty_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    output logic [DATA_WIDTH/8-1:0]           s_sel_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [2:0]                        s_cti_o,
    output logic [1:0]                        s_bte_o,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    input  logic                              s_ack_i,
    input  logic                              s_err_i,
    input  logic                              s_rty_i,
    output logic [NUM_PORTS-1:0]              grant_o,
    output logic                              timeout_o
);

    localparam int SW   = DATA_WIDTH / 8;
    localparam int IW   = $clog2(NUM_PORTS);
    localparam int WW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int TMAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state;
    logic [NUM_PORTS-1:0]  grant;
    logic [IW-1:0]         last;
    logic [WW-1:0]         wd_cnt;

    logic                  busy;
    logic [IW-1:0]         idx;
    logic                  gcyc;
    logic                  gstb;
    logic                  resp;
    logic                  wd_fire;
    logic                  pick_found;
    logic [IW-1:0]         pick_idx;

    // In BUSY, last is the current grantee; idle outputs come from port 0.
    assign busy = (state == BUSY);
    assign idx  = busy ? last : '0;
    assign gcyc = busy & m_cyc_i[idx];
    assign gstb = busy & m_stb_i[idx];
    assign resp = s_ack_i | s_err_i | s_rty_i;

    // A slave response on the final waiting cycle beats the watchdog.
    assign wd_fire = (TIMEOUT > 0) && gstb && !resp &&
                     (wd_cnt == WW'(TMAX));

    // Round-robin search for the next requester, starting after last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            if (!pick_found &&
                m_cyc_i[(int'(last) + i) % NUM_PORTS]) begin
                pick_found = 1'b1;
                pick_idx   = IW'((int'(last) + i) % NUM_PORTS);
            end
        end
    end

    // Slave request mux from the granted port.
    assign s_adr_o = m_adr_i[idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_dat_o = m_dat_i[idx*DATA_WIDTH +: DATA_WIDTH];
    assign s_sel_o = m_sel_i[idx*SW +: SW];
    assign s_cti_o = m_cti_i[idx*3 +: 3];
    assign s_bte_o = m_bte_i[idx*2 +: 2];
    assign s_cyc_o = gcyc & ~wd_fire;
    assign s_stb_o = gstb & ~wd_fire;
    assign s_we_o  = busy & m_we_i[idx];

    // Responses are steered only to the granted port.
    assign m_dat_o   = {NUM_PORTS{s_dat_i}};
    assign m_ack_o   = grant & {NUM_PORTS{s_ack_i}};
    assign m_err_o   = grant & {NUM_PORTS{s_err_i | wd_fire}};
    assign m_rty_o   = grant & {NUM_PORTS{s_rty_i}};
    assign grant_o   = grant;
    assign timeout_o = wd_fire;

    // Grant FSM with watchdog counter.
    always_ff @(posedge clk) begin
        if (rst_sys) begin
            state  <= IDLE;
            grant  <= '0;
            last   <= IW'(NUM_PORTS - 1);
            wd_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (pick_found) begin
                        grant <= NUM_PORTS'(1) << pick_idx;
                        last  <= pick_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!m_cyc_i[last]) begin
                        grant  <= '0;
                        wd_cnt <= '0;
                        state  <= IDLE;
                    end else if (wd_fire || resp || !gstb) begin
                        wd_cnt <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + WW'(1);
                    end
                end
                default: begin
                    grant  <= '0;
                    wd_cnt <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ext_arbiter.sv
// Directed self-checking bench for wb_ext_arbiter.
// Four ports, watchdog TIMEOUT of 16 cycles.
module tb_wb_ext_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic               clk = 1'b0;
    logic               rst_sys;
    logic [NP*AW-1:0]   m_adr_i;
    logic [NP*DW-1:0]   m_dat_i;
    logic [NP*DW/8-1:0] m_sel_i;
    logic [NP-1:0]      m_cyc_i;
    logic [NP-1:0]      m_stb_i;
    logic [NP-1:0]      m_we_i;
    logic [NP*3-1:0]    m_cti_i;
    logic [NP*2-1:0]    m_bte_i;
    logic [NP*DW-1:0]   m_dat_o;
    logic [NP-1:0]      m_ack_o;
    logic [NP-1:0]      m_err_o;
    logic [NP-1:0]      m_rty_o;
    logic [AW-1:0]      s_adr_o;
    logic [DW-1:0]      s_dat_o;
    logic [DW/8-1:0]    s_sel_o;
    logic               s_cyc_o;
    logic               s_stb_o;
    logic               s_we_o;
    logic [2:0]         s_cti_o;
    logic [1:0]         s_bte_o;
    logic [DW-1:0]      s_dat_i;
    logic               s_ack_i;
    logic               s_err_i;
    logic               s_rty_i;
    logic [NP-1:0]      grant_o;
    logic               timeout_o;

    int n_chk  = 0;
    int n_pass = 0;

    wb_ext_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (16)
    ) dut (
        .clk      (clk),
        .rst_sys  (rst_sys),
        .m_adr_i  (m_adr_i),
        .m_dat_i  (m_dat_i),
        .m_sel_i  (m_sel_i),
        .m_cyc_i  (m_cyc_i),
        .m_stb_i  (m_stb_i),
        .m_we_i   (m_we_i),
        .m_cti_i  (m_cti_i),
        .m_bte_i  (m_bte_i),
        .m_dat_o  (m_dat_o),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .m_rty_o  (m_rty_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_cti_o  (s_cti_o),
        .s_bte_o  (s_bte_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .s_err_i  (s_err_i),
        .s_rty_i  (s_rty_i),
        .grant_o  (grant_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic req(input int p, input logic on,
                       input logic we, input logic [31:0] adr);
        m_cyc_i[p]          = on;
        m_stb_i[p]          = on;
        m_we_i[p]           = we;
        m_adr_i[p*AW +: AW] = adr;
    endtask

    initial begin
        rst_sys = 1'b1;
        m_adr_i = '0;
        m_dat_i = '0;
        m_sel_i = '1;
        m_cyc_i = '1;
        m_stb_i = '0;
        m_we_i  = '0;
        m_cti_i = '0;
        m_bte_i = '0;
        s_dat_i = '0;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_rty_i = 1'b0;

        // Reset held 3 cycles with all ports requesting.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_grant", 64'(grant_o), 64'h0);
            chk("rst_scyc", 64'(s_cyc_o), 64'h0);
        end
        chk("rst_resp", 64'({m_ack_o, m_err_o, m_rty_o, timeout_o}), 64'h0);
        rst_sys = 1'b0;
        tick();
        chk("rst_first", 64'(grant_o), 64'h1);
        m_cyc_i = '0;
        tick();
        chk("rst_drop", 64'(grant_o), 64'h0);

        // Round robin: re-reset so port 0 leads, then order 0,1,2,3,0.
        rst_sys = 1'b1;
        tick();
        rst_sys = 1'b0;
        for (int p = 0; p < NP; p++)
            req(p, 1'b1, 1'b0, 32'h100 + 32'(p));
        for (int k = 0; k < 5; k++) begin
            int p;
            p = k % NP;
            tick();
            chk("rr_grant", 64'(grant_o), 64'(4'b0001 << p));
            chk("rr_adr", 64'(s_adr_o), 64'(32'h100 + 32'(p)));
            tick();
            s_ack_i = 1'b1;
            s_dat_i = 32'hA0 + 32'(p);
            settle();
            chk("rr_ack", 64'(m_ack_o), 64'(4'b0001 << p));
            chk("rr_dat", 64'(m_dat_o[p*DW +: DW]), 64'(32'hA0 + 32'(p)));
            tick();
            s_ack_i = 1'b0;
            req(p, 1'b0, 1'b0, 32'h100 + 32'(p));
            tick();
            chk("rr_gap", 64'(grant_o), 64'h0);
            req(p, 1'b1, 1'b0, 32'h100 + 32'(p));
        end
        m_cyc_i = '0;
        m_stb_i = '0;
        tick();
        tick();

        // Burst hold: port 2 eight-beat burst while port 3 waits.
        req(2, 1'b1, 1'b0, 32'h2000);
        req(3, 1'b1, 1'b0, 32'h3000);
        m_cti_i[6 +: 3] = 3'b010;
        tick();
        chk("bu_grant", 64'(grant_o), 64'h4);
        s_ack_i = 1'b1;
        for (int b = 0; b < 8; b++) begin
            m_adr_i[2*AW +: AW] = 32'h2000 + 32'(4 * b);
            m_cti_i[6 +: 3]     = (b == 7) ? 3'b111 : 3'b010;
            settle();
            chk("bu_adr", 64'(s_adr_o), 64'(32'h2000 + 32'(4 * b)));
            chk("bu_ack", 64'({grant_o, m_ack_o}), 64'h44);
            tick();
        end
        s_ack_i = 1'b0;
        req(2, 1'b0, 1'b0, 32'h0);
        m_cti_i[6 +: 3] = 3'b000;
        tick();
        chk("bu_dead", 64'({grant_o, s_cyc_o}), 64'h0);
        tick();
        chk("bu_next", 64'(grant_o), 64'h8);
        req(3, 1'b0, 1'b0, 32'h0);
        tick();
        tick();

        // Watchdog: port 1 hangs, port 0 waits behind it.
        req(1, 1'b1, 1'b0, 32'h1000);
        tick();
        chk("wd_grant", 64'(grant_o), 64'h2);
        req(0, 1'b1, 1'b0, 32'h0);
        for (int w = 1; w < 16; w++) begin
            settle();
            chk("wd_wait", 64'({timeout_o, m_err_o, s_stb_o}), 64'h1);
            tick();
        end
        chk("wd_err", 64'(m_err_o), 64'h2);
        chk("wd_pulse", 64'(timeout_o), 64'h1);
        chk("wd_kill", 64'({s_stb_o, s_cyc_o}), 64'h0);
        tick();
        chk("wd_clr", 64'({timeout_o, m_err_o}), 64'h0);
        chk("wd_hold", 64'(grant_o), 64'h2);
        tick();
        chk("wd_hold2", 64'(grant_o), 64'h2);
        req(1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("wd_idle", 64'(grant_o), 64'h0);
        tick();
        chk("wd_next", 64'(grant_o), 64'h1);
        req(0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();

        // Race: ack lands on the watchdog cycle.
        req(1, 1'b1, 1'b0, 32'h1004);
        tick();
        chk("ra_grant", 64'(grant_o), 64'h2);
        for (int w = 1; w < 16; w++)
            tick();
        s_ack_i = 1'b1;
        settle();
        chk("ra_ack", 64'(m_ack_o), 64'h2);
        chk("ra_err", 64'(m_err_o), 64'h0);
        chk("ra_to", 64'(timeout_o), 64'h0);
        chk("ra_stb", 64'(s_stb_o), 64'h1);
        tick();
        s_ack_i = 1'b0;
        req(1, 1'b0, 1'b0, 32'h0);
        tick();
        tick();

        // Mid-operation reset during a port 0 write.
        req(0, 1'b1, 1'b1, 32'h40);
        tick();
        chk("mr_grant", 64'({grant_o, s_we_o}), 64'h3);
        req(1, 1'b1, 1'b0, 32'h44);
        rst_sys = 1'b1;
        tick();
        chk("mr_rst", 64'({grant_o, s_cyc_o, m_ack_o}), 64'h0);
        rst_sys = 1'b0;
        tick();
        chk("mr_regrant", 64'(grant_o), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
